// File: rtl/request_unit_pkg.sv
// Shared types for the memory request sequencer that sits behind the control unit.
package request_unit_pkg;

    typedef enum logic [1:0] {
        IFETCH  = 2'd0,
        DACCESS = 2'd1,
        HALTED  = 2'd2
    } ru_state_t;

    // A store takes precedence when the decoder raises both intents.
    function automatic logic [1:0] resolve_request(input logic ren, input logic wen);
        return {wen, ren & ~wen};
    endfunction

endpackage

// File: rtl/ru_sat_counter.sv
// Saturating up-counter: holds at all-ones, and holds its value while freeze is high.
module ru_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (en && !freeze && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer: holds data requests until dhit, gates PC advance, sticky halt.
// Optional statistics counters are built when REQUEST_UNIT_STATS_EN is defined.
module request_unit
    import request_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dRENi,
    input  logic             dWENi,
    input  logic             halti,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pcEN,
`ifdef REQUEST_UNIT_STATS_EN
    output logic             halt,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_cycles
`else
    output logic             halt
`endif
);

    ru_state_t state_reg, state_next;
    logic      dmem_ren_reg, dmem_ren_next;
    logic      dmem_wen_reg, dmem_wen_next;
    logic      halt_reg, halt_next;
    logic [1:0] req_resolved;

    assign req_resolved = resolve_request(dRENi, dWENi);

    always_comb begin
        state_next    = state_reg;
        dmem_ren_next = dmem_ren_reg;
        dmem_wen_next = dmem_wen_reg;
        imemREN       = 1'b0;
        pcEN          = 1'b0;

        case (state_reg)
            IFETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    if (halti) begin
                        state_next = HALTED;
                    end else if (dRENi || dWENi) begin
                        state_next    = DACCESS;
                        dmem_wen_next = req_resolved[1];
                        dmem_ren_next = req_resolved[0];
                    end else begin
                        pcEN = 1'b1;
                    end
                end
            end
            DACCESS: begin
                // Request stays stable until the cache completes it.
                if (dhit) begin
                    pcEN          = 1'b1;
                    dmem_ren_next = 1'b0;
                    dmem_wen_next = 1'b0;
                    state_next    = IFETCH;
                end
            end
            HALTED: begin
                dmem_ren_next = 1'b0;
                dmem_wen_next = 1'b0;
            end
            default: begin
                state_next    = IFETCH;
                dmem_ren_next = 1'b0;
                dmem_wen_next = 1'b0;
            end
        endcase

        halt_next = (state_next == HALTED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IFETCH;
            dmem_ren_reg <= 1'b0;
            dmem_wen_reg <= 1'b0;
            halt_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dmem_ren_reg <= dmem_ren_next;
            dmem_wen_reg <= dmem_wen_next;
            halt_reg     <= halt_next;
        end
    end

    assign dmemREN = dmem_ren_reg;
    assign dmemWEN = dmem_wen_reg;
    assign halt    = halt_reg;

`ifdef REQUEST_UNIT_STATS_EN
    logic stall_en;
    logic stats_freeze;

    assign stall_en     = ((state_reg == IFETCH) && !ihit) ||
                          ((state_reg == DACCESS) && !dhit);
    assign stats_freeze = (state_reg == HALTED);

    ru_sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .en     (pcEN),
        .freeze (stats_freeze),
        .count  (instr_count)
    );

    ru_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .en     (stall_en),
        .freeze (stats_freeze),
        .count  (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: a per-cycle reference model pushes expected outputs,
// which are popped and compared on the falling edge.
module tb_request_unit;

`ifdef REQUEST_UNIT_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    logic clk, rst, dreni, dweni, halti, ihit, dhit;
    logic imem_ren, dmem_ren, dmem_wen, pc_en, halt;
`ifdef REQUEST_UNIT_STATS_EN
    logic [CNT_W-1:0] instr_count, stall_cycles;
`endif

    request_unit #(.CNT_W(CNT_W)) dut (
        .CLK          (clk),
        .RST          (rst),
        .dRENi        (dreni),
        .dWENi        (dweni),
        .halti        (halti),
        .ihit         (ihit),
        .dhit         (dhit),
        .imemREN      (imem_ren),
        .dmemREN      (dmem_ren),
        .dmemWEN      (dmem_wen),
        .pcEN         (pc_en),
`ifdef REQUEST_UNIT_STATS_EN
        .halt         (halt),
        .instr_count  (instr_count),
        .stall_cycles (stall_cycles)
`else
        .halt         (halt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             pcen;
        logic             imem;
        logic             dren;
        logic             dwen;
        logic             hlt;
        logic [CNT_W-1:0] instr;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pc_pulses = 0;
    int   cyc = 0;

    // Reference model: 0 = fetch, 1 = data access, 2 = halted
    int               m_state = 0;
    logic             m_ren = 1'b0, m_wen = 1'b0;
    logic [CNT_W-1:0] m_instr = '0, m_stall = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input logic r, input logic ir, input logic iw,
                        input logic ih, input logic ii, input logic dh);
        exp_t e, x;
        logic stall_inc;
        rst = r; dreni = ir; dweni = iw; ihit = ih; halti = ii; dhit = dh;
        e.pcen  = (m_state == 0 && ih && !ii && !ir && !iw) || (m_state == 1 && dh);
        e.imem  = (m_state == 0);
        e.dren  = m_ren;
        e.dwen  = m_wen;
        e.hlt   = (m_state == 2);
        e.instr = m_instr;
        e.stall = m_stall;
        sb_q.push_back(e);

        @(negedge clk);
        x = sb_q.pop_front();
        check("pcEN", pc_en, x.pcen);
        check("imemREN", imem_ren, x.imem);
        check("dmemREN", dmem_ren, x.dren);
        check("dmemWEN", dmem_wen, x.dwen);
        check("halt", halt, x.hlt);
`ifdef REQUEST_UNIT_STATS_EN
        check("instr_count", instr_count, x.instr);
        check("stall_cycles", stall_cycles, x.stall);
`endif
        if (pc_en === 1'b1) pc_pulses++;
        $display("cyc %0d rst=%b r=%b w=%b ih=%b h=%b dh=%b -> imem=%b dren=%b dwen=%b pc=%b halt=%b",
                 cyc, r, ir, iw, ih, ii, dh, imem_ren, dmem_ren, dmem_wen, pc_en, halt);

        @(posedge clk);
        stall_inc = (m_state == 0 && !ih) || (m_state == 1 && !dh);
        if (r) begin
            m_state = 0; m_ren = 1'b0; m_wen = 1'b0; m_instr = '0; m_stall = '0;
        end else begin
            if (x.pcen && m_instr != {CNT_W{1'b1}}) m_instr = m_instr + 1'b1;
            if (stall_inc && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
            if (m_state == 0 && ih) begin
                if (ii) m_state = 2;
                else if (ir || iw) begin
                    m_state = 1; m_wen = iw; m_ren = ir && !iw;
                end
            end else if (m_state == 1 && dh) begin
                m_state = 0; m_ren = 1'b0; m_wen = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1'b1; dreni = 1'b0; dweni = 1'b0; halti = 1'b0; ihit = 1'b0; dhit = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then three back-to-back ALU retirements
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

        // LW with four miss cycles; spurious ihit in DACCESS must be ignored
        pc_pulses = 0;
        step(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, $urandom_range(0, 1), 0, $urandom_range(0, 1), 0, 0);
        step(0, 0, 0, 1, 0, 1);
        check("lw_pcen_pulses", pc_pulses, 1);

        // Both intents: store wins
        step(0, 1, 1, 1, 0, 0);
        check("both_wen", dmem_wen, 1);
        check("both_ren", dmem_ren, 0);
        step(0, 0, 0, 0, 0, 1);

        // dhit while fetching is ignored
        step(0, 0, 0, 0, 0, 1);

        // Reset in the second DACCESS wait cycle; following dhit retires nothing
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("rst_daccess_imem", imem_ren, 1);

        // Random traffic without halt
        for (int i = 0; i < 30; i++)
            step(0, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), 0, $urandom_range(0, 1));
        while (m_state != 0) step(0, 0, 0, 0, 0, 1);

        // HALT beats the store; halted state is absorbing
        step(0, 0, 1, 1, 1, 0);
        check("halt_rise", halt, 1);
        check("halt_no_wen", dmem_wen, 0);
        for (int i = 0; i < 10; i++)
            step(0, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        check("halt_sticky", halt, 1);

        // Reset out of HALTED
        step(1, 0, 0, 1, 1, 1);
        check("halt_cleared", halt, 0);
        step(0, 0, 0, 0, 0, 0);

`ifdef REQUEST_UNIT_STATS_EN
        // Saturation: narrow counter must hold at all-ones
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0);
        check("instr_sat", instr_count, {CNT_W{1'b1}});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/request_unit.md
# request_unit

Memory request sequencer directly downstream of the control unit in the single-cycle MIPS datapath. Takes the decoder's raw load/store/halt intents (`dRENi`, `dWENi`, `halti`) and turns them into cache-facing requests. It holds each data request until the cache acknowledges it. It also gates PC advance and produces a sticky processor halt. All wait states caused by instruction and data cache misses are handled here.

## Interface
Parameters:
- `CNT_W`, default 32: width of the statistics counters. Used only when `REQUEST_UNIT_STATS_EN` is defined.

Ports, bundled in `request_unit_if.vh` with modport `ru`:
- `CLK`  in  1: the single clock; all state updates on its rising edge.
- `RST`  in  1: reset; synchronous, active-high.
- `dRENi`  in  1: decoded load intent from the control unit.
- `dWENi`  in  1: decoded store intent from the control unit.
- `halti`  in  1: decoded HALT from the control unit.
- `ihit`  in  1: instruction cache has a valid word this cycle.
- `dhit`  in  1: data cache has completed the pending access this cycle.
- `imemREN`  out  1: instruction read request.
- `dmemREN`  out  1: data read request, registered.
- `dmemWEN`  out  1: data write request, registered.
- `pcEN`  out  1: PC advance / instruction retire strobe, combinational.
- `halt`  out  1: sticky processor halt, registered.
- `instr_count`  out  `CNT_W`: retired instruction count. Present only with the macro.
- `stall_cycles`  out  `CNT_W`: cycles spent waiting on a cache. Present only with the macro.

## Operation
- FSM states: `IFETCH`, `DACCESS`, `HALTED`. Reset state is `IFETCH`.
- `IFETCH`:
  - `imemREN`=1; `dmemREN`=`dmemWEN`=0.
  - `ihit`=0: stay in `IFETCH`.
  - `ihit`=1 and `halti`=1: go to `HALTED`, with `pcEN`=0. `halti` has priority over `dRENi` and `dWENi`.
  - `ihit`=1 and (`dRENi` or `dWENi`): go to `DACCESS` with `pcEN`=0.
    - Register the requests: `dmemWEN`<=`dWENi`, `dmemREN`<=`dRENi & ~dWENi`. A store wins if both are set.
  - `ihit`=1, no intent: `pcEN`=1; stay in `IFETCH`.
- `DACCESS`:
  - `imemREN`=0; the registered request is held stable.
  - `dhit`=0: stay in `DACCESS`.
  - `dhit`=1: `pcEN`=1 in the same cycle; clear `dmemREN` and `dmemWEN` at the edge; return to `IFETCH`.
  - `halti`, `dRENi`, `dWENi` and `ihit` are ignored in this state.
- `HALTED`:
  - All requests are 0 and `pcEN`=0; `halt`=1.
  - The state is absorbing until `RST`.
- `pcEN` = (`IFETCH` & `ihit` & ~`halti` & ~`dRENi` & ~`dWENi`) | (`DACCESS` & `dhit`).
- `dhit` while in `IFETCH` is ignored. A spurious `ihit` while in `DACCESS` is ignored.

## Timing
- Reset values after `RST` is sampled high:
  - state = `IFETCH`
  - `imemREN`=1
  - `dmemREN`=0
  - `dmemWEN`=0
  - `halt`=0
  - `pcEN`=0 until `ihit`
  - counters = 0
- ALU/R-type instruction: retires in the `ihit` cycle, with 0 extra cycles.
- Load/store instruction:
  - Data request is visible 1 cycle after `ihit`.
  - Retires in the `dhit` cycle.
  - Minimum 2 cycles per memory instruction.
- Halt: `halt` rises 1 cycle after the `ihit` cycle that carries `halti`.
- `RST` in `DACCESS` or `HALTED`: requests drop and `halt` clears at that edge; the FSM returns to `IFETCH`.

## Configuration
- `REQUEST_UNIT_STATS_EN`:
  - Defined: `instr_count` and `stall_cycles` exist.
    - `instr_count` increments when `pcEN`=1.
    - `stall_cycles` increments in `IFETCH` with ~`ihit`, and in `DACCESS` with ~`dhit`.
    - Both saturate at all-ones and freeze in `HALTED`.
  - Undefined: both ports and all counter logic are absent. No other behaviour changes.

## Structure
- Add `ru_state_t` (`IFETCH`, `DACCESS`, `HALTED`) to the shared `control_unit_types_pkg`.
- `request_unit_if.vh` declares the signals above, with modport `ru` for this block and modport `tb` for the bench.
- Sub-module `ru_sat_counter`: a `CNT_W`-wide saturating counter with `RST`, `en` and `freeze`. It is instantiated twice, under the macro only.

## Test plan
- Reset, then `ihit`=1 with no intent for 3 cycles -> `pcEN`=1 each cycle, `dmemREN`=`dmemWEN`=0, `halt`=0. With stats, `instr_count`=3.
- LW: `ihit`=1 and `dRENi`=1, then `dhit` low for 4 cycles, then high:
  - `dmemREN`=1 for 5 cycles and `imemREN`=0 throughout.
  - `pcEN` pulses once, in the `dhit` cycle.
  - With stats, `stall_cycles`=4.
- `dRENi`=`dWENi`=1 with `ihit` -> `dmemWEN`=1 and `dmemREN`=0 on the next cycle.
- HALT: `halti`=1 and `dWENi`=1 with `ihit` -> next cycle `halt`=1 and `dmemWEN`=0. `pcEN` stays 0 and `halt` stays 1 for the next 10 cycles regardless of inputs.
- `RST` asserted in the 2nd `DACCESS` wait cycle -> next cycle `dmemREN`=0 and `imemREN`=1. A following `dhit`=1 produces no `pcEN`.
- With stats, force `instr_count` to all-ones minus 1, then 3 retirements -> the value holds at all-ones.
